// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered count, level flags, sticky
// overflow/underflow flags and a selectable standard / first-word-fall-through
// read port. Storage is a plain 1W1R array so it can map onto block RAM.
module sync_fifo #(
   parameter int WIDTH         = 36,
   parameter int DEPTH         = 256,
   parameter int AFULL_THRESH  = DEPTH - 4,
   parameter int AEMPTY_THRESH = 4,
   parameter int FWFT          = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     wen,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     ren,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     almost_empty,
   output logic                     almost_full,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic             wr_acc;
   logic             rd_acc;
   logic             bypass;

   // Level flags come only from the registered count, never from requests.
   assign empty        = (count_q == '0);
   assign full         = (count_q == DEPTH_C);
   assign almost_empty = (count_q <= AEMPTY_C);
   assign almost_full  = (count_q >= AFULL_C);

   assign rdata     = rdata_q;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   // Next-state: accept decisions, pointers, occupancy, sticky errors, read data.
   always_comb begin
      wr_acc      = wen && !full && !clr;
      rd_acc      = ren && !empty && !clr;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q | (wen & full);
      underflow_d = underflow_q | (ren & empty);
      rdata_d     = rdata_q;
      bypass      = 1'b0;

      if (wr_acc) wptr_d = wptr_q + AW'(1);
      if (rd_acc) rptr_d = rptr_q + AW'(1);

      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (FWFT != 0) begin
         // Keep the register tracking the next head word. The only time the
         // next head is being written on this same edge is when it lands in
         // an (effectively) empty FIFO, so forward wdata instead of the stale
         // array contents.
         bypass  = wr_acc && (wptr_q == rptr_d);
         rdata_d = bypass ? wdata : mem[rptr_d];
      end else if (rd_acc) begin
         rdata_d = mem[rptr_q];
      end

      if (clr) begin
         wptr_d      = '0;
         rptr_d      = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
         rdata_d     = '0;
      end
   end

   // State registers; storage array is deliberately excluded from reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         rdata_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         rdata_q     <= rdata_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Single write port into the storage array.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wptr_q] <= wdata;
   end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a standard-read and a FWFT instance share
// stimulus; each task drives one scenario and checks against hand values.
module tb_sync_fifo;

   localparam int W = 8;
   localparam int D = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         clr = 1'b0;
   logic         wen = 1'b0;
   logic         ren = 1'b0;
   logic [W-1:0] wdata = '0;

   logic [W-1:0] rdata0, rdata1;
   logic [3:0]   count0, count1;
   logic         empty0, full0, ae0, af0, ovf0, unf0;
   logic         empty1, full1, ae1, af1, ovf1, unf1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sync_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(0)) u_std (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wen(wen), .wdata(wdata), .ren(ren),
      .rdata(rdata0), .count(count0), .empty(empty0), .full(full0),
      .almost_empty(ae0), .almost_full(af0), .overflow(ovf0), .underflow(unf0));

   sync_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(1)) u_fwft (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wen(wen), .wdata(wdata), .ren(ren),
      .rdata(rdata1), .count(count1), .empty(empty1), .full(full1),
      .almost_empty(ae1), .almost_full(af1), .overflow(ovf1), .underflow(unf1));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_clr;
      clr = 1'b1; wen = 1'b0; ren = 1'b0;
      tick();
      clr = 1'b0;
   endtask

   task automatic test_reset;
      #3;
      n_tests++; if (count0 !== 4'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", count0); end
      n_tests++; if ({empty0, full0, ae0, af0, ovf0, unf0} !== 6'b101000) begin n_fail++; $display("FAIL rst_flags got %b exp 101000", {empty0, full0, ae0, af0, ovf0, unf0}); end
      n_tests++; if (rdata0 !== 8'h00) begin n_fail++; $display("FAIL rst_rdata got %h exp 00", rdata0); end
      // Request a write so it is pending on the first edge after release.
      wen = 1'b1; wdata = 8'h11;
      #9 rst_n = 1'b1;
      tick();
      wen = 1'b0;
      n_tests++; if (count0 !== 4'd1) begin n_fail++; $display("FAIL first_edge_count got %0d exp 1", count0); end
      n_tests++; if (rdata1 !== 8'h11 || empty1 !== 1'b0) begin n_fail++; $display("FAIL first_edge_fwft got %h/%b exp 11/0", rdata1, empty1); end
      do_clr();
   endtask

   task automatic test_fill_drain;
      for (int i = 1; i <= 8; i++) begin
         wen = 1'b1; wdata = W'(i);
         tick();
      end
      wen = 1'b0;
      n_tests++; if (full0 !== 1'b1 || count0 !== 4'd8) begin n_fail++; $display("FAIL fill_full got %b/%0d exp 1/8", full0, count0); end
      n_tests++; if (rdata1 !== 8'd1) begin n_fail++; $display("FAIL fill_fwft_head got %0d exp 1", rdata1); end
      for (int i = 1; i <= 8; i++) begin
         ren = 1'b1;
         tick();
         n_tests++; if (rdata0 !== W'(i)) begin n_fail++; $display("FAIL drain_data got %0d exp %0d", rdata0, i); end
         if (i < 8) begin
            n_tests++; if (rdata1 !== W'(i + 1)) begin n_fail++; $display("FAIL drain_fwft got %0d exp %0d", rdata1, i + 1); end
         end
      end
      ren = 1'b0;
      n_tests++; if (empty0 !== 1'b1 || count0 !== 4'd0) begin n_fail++; $display("FAIL drain_empty got %b/%0d exp 1/0", empty0, count0); end
   endtask

   task automatic test_wrap;
      do_clr();
      for (int i = 0; i < 3; i++) begin
         wen = 1'b1; wdata = W'(100 + i);
         tick();
      end
      for (int k = 0; k < 20; k++) begin
         wen = 1'b1; ren = 1'b1; wdata = W'(103 + k);
         tick();
         n_tests++; if (count0 !== 4'd3) begin n_fail++; $display("FAIL wrap_count got %0d exp 3", count0); end
         n_tests++; if (rdata0 !== W'(100 + k)) begin n_fail++; $display("FAIL wrap_data got %0d exp %0d", rdata0, 100 + k); end
      end
      wen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         ren = 1'b1;
         tick();
         n_tests++; if (rdata0 !== W'(120 + k)) begin n_fail++; $display("FAIL wrap_tail got %0d exp %0d", rdata0, 120 + k); end
      end
      ren = 1'b0;
      n_tests++; if (empty0 !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %b exp 1", empty0); end
   endtask

   task automatic test_over_under;
      do_clr();
      for (int i = 1; i <= 8; i++) begin
         wen = 1'b1; wdata = W'(8'h50 + i);
         tick();
      end
      wdata = 8'hEE;
      tick();
      n_tests++; if (ovf0 !== 1'b1 || count0 !== 4'd8) begin n_fail++; $display("FAIL overflow got %b/%0d exp 1/8", ovf0, count0); end
      // Write while full is dropped even though the read frees a slot.
      ren = 1'b1; wdata = 8'hEF;
      tick();
      wen = 1'b0;
      n_tests++; if (count0 !== 4'd7 || rdata0 !== 8'h51) begin n_fail++; $display("FAIL full_rw got %0d/%h exp 7/51", count0, rdata0); end
      for (int i = 2; i <= 8; i++) begin
         tick();
         n_tests++; if (rdata0 !== W'(8'h50 + i)) begin n_fail++; $display("FAIL ovf_drain got %h exp %h", rdata0, 8'h50 + i); end
      end
      tick();
      ren = 1'b0;
      n_tests++; if (unf0 !== 1'b1 || count0 !== 4'd0 || rdata0 !== 8'h58) begin n_fail++; $display("FAIL underflow got %b/%0d/%h exp 1/0/58", unf0, count0, rdata0); end
      n_tests++; if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", ovf0); end
      do_clr();
      n_tests++; if ({ovf0, unf0} !== 2'b00 || count0 !== 4'd0 || rdata0 !== 8'h00) begin n_fail++; $display("FAIL clr got %b/%0d/%h exp 00/0/00", {ovf0, unf0}, count0, rdata0); end
   endtask

   task automatic test_thresh;
      do_clr();
      for (int k = 1; k <= 8; k++) begin
         wen = 1'b1; wdata = W'(k);
         tick();
         n_tests++; if (ae0 !== (k <= 2)) begin n_fail++; $display("FAIL almost_empty got %b at count %0d", ae0, k); end
         n_tests++; if (af0 !== (k >= 6)) begin n_fail++; $display("FAIL almost_full got %b at count %0d", af0, k); end
      end
      wen = 1'b0;
      do_clr();
   endtask

   task automatic test_fwft;
      wen = 1'b1; wdata = 8'hA5;
      tick();
      wen = 1'b0;
      n_tests++; if (rdata1 !== 8'hA5 || empty1 !== 1'b0) begin n_fail++; $display("FAIL fwft_visible got %h/%b exp a5/0", rdata1, empty1); end
      n_tests++; if (rdata0 !== 8'h00) begin n_fail++; $display("FAIL std_not_early got %h exp 00", rdata0); end
      ren = 1'b1;
      tick();
      ren = 1'b0;
      n_tests++; if (empty1 !== 1'b1) begin n_fail++; $display("FAIL fwft_pop got %b exp 1", empty1); end
      n_tests++; if (rdata0 !== 8'hA5) begin n_fail++; $display("FAIL std_after_ren got %h exp a5", rdata0); end
      wen = 1'b1; wdata = 8'hB1;
      tick();
      wdata = 8'hB2;
      tick();
      wen = 1'b0;
      n_tests++; if (rdata1 !== 8'hB1) begin n_fail++; $display("FAIL fwft_head_hold got %h exp b1", rdata1); end
      ren = 1'b1;
      tick();
      ren = 1'b0;
      n_tests++; if (rdata1 !== 8'hB2 || count1 !== 4'd1) begin n_fail++; $display("FAIL fwft_advance got %h/%0d exp b2/1", rdata1, count1); end
      do_clr();
   endtask

   task automatic test_reset_mid;
      for (int i = 1; i <= 6; i++) begin
         wen = 1'b1; wdata = W'(8'h30 + i);
         tick();
      end
      wen = 1'b0; ren = 1'b1;
      tick();
      ren = 1'b0; wen = 1'b1; wdata = 8'h3F;
      n_tests++; if (count0 !== 4'd5 || rdata0 !== 8'h31) begin n_fail++; $display("FAIL pre_rst got %0d/%h exp 5/31", count0, rdata0); end
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (count0 !== 4'd0 || empty0 !== 1'b1 || rdata0 !== 8'h00) begin n_fail++; $display("FAIL async_rst got %0d/%b/%h exp 0/1/00", count0, empty0, rdata0); end
      n_tests++; if (count1 !== 4'd0 || empty1 !== 1'b1) begin n_fail++; $display("FAIL async_rst_fwft got %0d/%b exp 0/1", count1, empty1); end
      wen = 1'b0;
      #10 rst_n = 1'b1;
      tick();
      n_tests++; if (count0 !== 4'd0 || empty0 !== 1'b1) begin n_fail++; $display("FAIL post_rst got %0d/%b exp 0/1", count0, empty0); end
      wen = 1'b1; wdata = 8'h77;
      tick();
      wen = 1'b0; ren = 1'b1;
      tick();
      ren = 1'b0;
      n_tests++; if (rdata0 !== 8'h77 || empty0 !== 1'b1) begin n_fail++; $display("FAIL post_rst_data got %h/%b exp 77/1", rdata0, empty0); end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_wrap();
      test_over_under();
      test_thresh();
      test_fwft();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 36: data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 256: number of entries; a power of two, at least 4.
REQ-003 The block SHALL have parameter AFULL_THRESH, default DEPTH-4: almost_full level; legal range is 1 to DEPTH.
REQ-004 The block SHALL have parameter AEMPTY_THRESH, default 4: almost_empty level; legal range is 0 to DEPTH-1.
REQ-005 The block SHALL have parameter FWFT, default 0: read mode; 0 is standard registered read, 1 is first-word-fall-through.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port clr, input, 1 bit: synchronous flush.
REQ-009 The block SHALL have port wen, input, 1 bit: write request.
REQ-010 The block SHALL have port wdata, input, WIDTH bits: write data.
REQ-011 The block SHALL have port ren, input, 1 bit: read request.
REQ-012 The block SHALL have port rdata, output, WIDTH bits: read data.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy, range 0 to DEPTH.
REQ-014 The block SHALL have output ports empty, full, almost_empty and almost_full, 1 bit each: level flags.
REQ-015 The block SHALL have output ports overflow and underflow, 1 bit each: sticky error flags.

Function
REQ-016 An accepted write SHALL occur when wen=1 and full=0 and clr=0; it stores wdata at wptr and increments wptr.
REQ-017 A write request while full=1 SHALL be dropped, even if a read is accepted in the same cycle.
REQ-018 An accepted read SHALL occur when ren=1 and empty=0 and clr=0; it increments rptr.
REQ-019 wptr and rptr SHALL be $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 without any extra logic.
REQ-020 count SHALL be a register updated each edge: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither are accepted.
REQ-021 The level flags SHALL be decoded only from registered count: empty=(count==0), full=(count==DEPTH), almost_empty=(count<=AEMPTY_THRESH), almost_full=(count>=AFULL_THRESH).
REQ-022 With FWFT=0, rdata SHALL load mem[rptr] on the edge of an accepted read, so data appears 1 cycle after ren; otherwise rdata holds its value.
REQ-023 With FWFT=1, rdata SHALL equal mem[rptr] whenever empty=0, so the head word is visible before ren; an accepted read advances to the next word on the following edge.
REQ-024 With FWFT=1, a word written into an empty FIFO SHALL become visible on rdata, with empty=0, in the cycle after the write edge.
REQ-025 When empty=1 and FWFT=1, rdata SHALL be don't-care for checking purposes.
REQ-026 overflow SHALL set on any edge with wen=1 and full=1, and SHALL stay set until clr or reset.
REQ-027 underflow SHALL set on any edge with ren=1 and empty=1, and SHALL stay set until clr or reset.
REQ-028 clr=1 SHALL take priority over wen and ren on that edge: wptr, rptr and count go to 0, overflow and underflow are cleared, rdata goes to 0, and memory is untouched.
REQ-029 The FIFO SHALL never read a word that has not been written; this holds at every wrap point.
REQ-030 The memory SHALL be inferable as block RAM with a single write port and a single read port; memory contents are not reset.

Reset
REQ-031 rst_n=0 SHALL immediately force wptr=0, rptr=0, count=0 and rdata=0, independent of clk.
REQ-032 During rst_n=0 the outputs SHALL be empty=1, full=0, almost_empty=1, almost_full=0, overflow=0 and underflow=0.
REQ-033 Reset asserted mid-operation SHALL discard all stored words; after release the FIFO behaves as freshly reset.
REQ-034 A write or read requested on the first clk edge after rst_n rises SHALL be honoured normally.

Verification
REQ-035 Fill/drain test (DEPTH=8, FWFT=0): write 1..8 on consecutive cycles, giving full=1 and count=8; then read 8, and rdata SHALL show 1..8 each 1 cycle after its ren, ending with empty=1.
REQ-036 Wrap test (DEPTH=8): run 20 interleaved write/read pairs starting from count=3; count SHALL stay 3 every cycle and data order SHALL be preserved across pointer wrap.
REQ-037 Overflow/underflow test: write while full=1, so overflow=1, count stays 8 and the extra word is never read back; read while empty=1, so underflow=1; then pulse clr, after which both flags are 0 and count=0.
REQ-038 Threshold test (AFULL_THRESH=6, AEMPTY_THRESH=2): almost_empty SHALL deassert on the edge where count goes 2 to 3, and almost_full SHALL assert on the edge where count goes 5 to 6.
REQ-039 FWFT test (FWFT=1): write 0xA5 to an empty FIFO; the next cycle SHALL show rdata=0xA5 and empty=0 with no ren; one ren then gives empty=1.
REQ-040 Reset test: assert rst_n=0 mid-burst with count=5, asynchronously to clk; outputs SHALL show count=0, empty=1 and rdata=0 before the next clk edge.
